// File: rtl/seq_divider.sv
// Multi-cycle 32-bit restoring divider with ALU-style N/Z/C/V flags, one quotient bit per clock.
// Define SIGNED_DIV_EN to honour sgn (magnitude conversion, sign fix-up, overflow flag).
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, p_q, p_d;
  logic [31:0] q_q, q_d, r_q, r_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic        ovf_q, ovf_d;
  logic [32:0] p_shift, p_diff;
  logic [31:0] a_mag, b_mag, q_fin, r_fin;
  logic        ovf_start;

`ifdef SIGNED_DIV_EN
  logic qsign_q, qsign_d, rsign_q, rsign_d;

  always_comb begin
    a_mag     = (sgn && a[31]) ? -a : a;
    b_mag     = (sgn && b[31]) ? -b : b;
    ovf_start = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    q_fin     = qsign_q ? -dvd_q : dvd_q;
    r_fin     = rsign_q ? -p_q : p_q;
  end
`else
  logic sgn_unused;
  assign sgn_unused = sgn;

  always_comb begin
    a_mag     = a;
    b_mag     = b;
    ovf_start = 1'b0;
    q_fin     = dvd_q;
    r_fin     = p_q;
  end
`endif

  // The dividend register doubles as the quotient: bits shift out the top, results enter at the bottom.
  assign p_shift = {p_q, dvd_q[31]};
  assign p_diff  = p_shift - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    q_d     = q_q;
    r_d     = r_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
`ifdef SIGNED_DIV_EN
    qsign_d = qsign_q;
    rsign_d = rsign_q;
`endif
    case (state_q)
      IDLE: begin
        // done_q still high here means we are in the done cycle, where start must be ignored.
        if (start && !done_q) begin
          if (b == 32'd0) begin
            q_d     = 32'd0;
            r_d     = a;
            n_d     = 1'b0;
            z_d     = 1'b1;
            c_d     = (a != 32'd0);
            v_d     = 1'b1;
            state_d = DONE;
          end else begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            p_d     = 32'd0;
            cnt_d   = 5'd31;
            ovf_d   = ovf_start;
`ifdef SIGNED_DIV_EN
            qsign_d = sgn && (a[31] ^ b[31]);
            rsign_d = sgn && a[31];
`endif
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = p_diff[32] ? p_shift[31:0] : p_diff[31:0];
        dvd_d = {dvd_q[30:0], ~p_diff[32]};
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      FIX: begin
        q_d     = q_fin;
        r_d     = r_fin;
        n_d     = q_fin[31];
        z_d     = (q_fin == 32'd0);
        c_d     = (r_fin != 32'd0);
        v_d     = ovf_q;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      p_q     <= 32'd0;
      ovf_q   <= 1'b0;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      q_q     <= q_d;
      r_q     <= r_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIGNED_DIV_EN
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign n    = n_q;
  assign z    = z_q;
  assign c    = c_q;
  assign v    = v_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; expectations follow SIGNED_DIV_EN when it is defined.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        n, z, c, v;

  int checks = 0;
  int passed = 0;

  seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sgn(sgn),
    .busy(busy), .done(done), .q(q), .r(r), .n(n), .z(z), .c(c), .v(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation, scrambles the operands after acceptance, and returns
  // the number of edges after the accepting edge at which done was first seen (-1 on timeout).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        output int lat, output logic busy_acc);
    @(negedge clk);
    a = ta; b = tb_v; sgn = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; sgn = ~ts;
    busy_acc = busy;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, q, r, n, z, c, v} !== 70'd0)
      $display("[TB] FAIL reset_outputs: got %h required 0", {busy, done, q, r, n, z, c, v});
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] va[3] = '{32'd100, 32'd5, 32'hFFFF_FFFF};
    logic [31:0] vb[3] = '{32'd7,   32'd9, 32'd1};
    logic [31:0] eq[3] = '{32'd14,  32'd0, 32'hFFFF_FFFF};
    logic [31:0] er[3] = '{32'd2,   32'd5, 32'd0};
    logic [3:0]  ef[3] = '{4'b0010, 4'b0110, 4'b1000};
    int lat;
    logic bacc;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, lat, bacc);
      checks++;
      if (lat !== 34) $display("[TB] FAIL unsigned_latency[%0d]: got %0d required 34", i, lat);
      else passed++;
      checks++;
      if (q !== eq[i]) $display("[TB] FAIL unsigned_q[%0d]: got %h required %h", i, q, eq[i]);
      else passed++;
      checks++;
      if (r !== er[i]) $display("[TB] FAIL unsigned_r[%0d]: got %h required %h", i, r, er[i]);
      else passed++;
      checks++;
      if ({n, z, c, v} !== ef[i])
        $display("[TB] FAIL unsigned_flags[%0d]: got %b required %b", i, {n, z, c, v}, ef[i]);
      else passed++;
      checks++;
      if ({bacc, busy} !== 2'b10)
        $display("[TB] FAIL unsigned_busy[%0d]: got %b required 10", i, {bacc, busy});
      else passed++;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00)
        $display("[TB] FAIL unsigned_done_pulse[%0d]: got %b required 00", i, {busy, done});
      else passed++;
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic bacc;
    run_op(32'h1234_5678, 32'd0, 1'b0, lat, bacc);
    checks++;
    if (lat !== 1) $display("[TB] FAIL divzero_latency: got %0d required 1", lat);
    else passed++;
    checks++;
    if ({q, r} !== {32'd0, 32'h1234_5678})
      $display("[TB] FAIL divzero_qr: got %h/%h required 0/12345678", q, r);
    else passed++;
    checks++;
    if ({n, z, c, v} !== 4'b0111) $display("[TB] FAIL divzero_flags: got %b required 0111", {n, z, c, v});
    else passed++;
    checks++;
    if ({bacc, busy} !== 2'b10) $display("[TB] FAIL divzero_busy: got %b required 10", {bacc, busy});
    else passed++;
  endtask

  task automatic test_signed();
    int lat;
    logic bacc;
    logic [31:0] eq0, er0, eq1, er1;
    logic [3:0]  ef0, ef1;
`ifdef SIGNED_DIV_EN
    eq0 = 32'hFFFF_FFF2; er0 = 32'hFFFF_FFFE; ef0 = 4'b1010;
    eq1 = 32'hFFFF_FFFD; er1 = 32'd1;        ef1 = 4'b1010;
`else
    eq0 = 32'h2492_4916; er0 = 32'd2;        ef0 = 4'b0010;
    eq1 = 32'd0;         er1 = 32'd7;        ef1 = 4'b0110;
`endif
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, lat, bacc);
    checks++;
    if (lat !== 34) $display("[TB] FAIL signed_latency: got %0d required 34", lat);
    else passed++;
    checks++;
    if ({q, r} !== {eq0, er0}) $display("[TB] FAIL signed_neg_dividend_qr: got %h/%h required %h/%h", q, r, eq0, er0);
    else passed++;
    checks++;
    if ({n, z, c, v} !== ef0) $display("[TB] FAIL signed_neg_dividend_flags: got %b required %b", {n, z, c, v}, ef0);
    else passed++;
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, lat, bacc);
    checks++;
    if ({q, r} !== {eq1, er1}) $display("[TB] FAIL signed_neg_divisor_qr: got %h/%h required %h/%h", q, r, eq1, er1);
    else passed++;
    checks++;
    if ({n, z, c, v} !== ef1) $display("[TB] FAIL signed_neg_divisor_flags: got %b required %b", {n, z, c, v}, ef1);
    else passed++;
  endtask

  task automatic test_overflow();
    int lat;
    logic bacc;
    logic [31:0] eq, er;
    logic [3:0]  ef;
`ifdef SIGNED_DIV_EN
    eq = 32'h8000_0000; er = 32'd0;         ef = 4'b1001;
`else
    eq = 32'd0;         er = 32'h8000_0000; ef = 4'b0110;
`endif
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bacc);
    checks++;
    if (lat !== 34) $display("[TB] FAIL overflow_latency: got %0d required 34", lat);
    else passed++;
    checks++;
    if ({q, r} !== {eq, er}) $display("[TB] FAIL overflow_qr: got %h/%h required %h/%h", q, r, eq, er);
    else passed++;
    checks++;
    if ({n, z, c, v} !== ef) $display("[TB] FAIL overflow_flags: got %b required %b", {n, z, c, v}, ef);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    int ndone = 0;
    int first = -1;
    logic busy_after = 1'b1;
    @(negedge clk);
    a = 32'd1000; b = 32'd10; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (40) begin
      @(negedge clk);
      start = 1'b0;
      if (lat == 35) busy_after = busy;
      if (lat == 4) begin start = 1'b1; a = 32'd7; b = 32'd2; end
      if (done) begin
        ndone++;
        if (first < 0) first = lat;
        start = 1'b1; a = 32'd50; b = 32'd5;
      end
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (ndone !== 1) $display("[TB] FAIL b2b_done_count: got %0d required 1", ndone);
    else passed++;
    checks++;
    if (first !== 34) $display("[TB] FAIL b2b_latency: got %0d required 34", first);
    else passed++;
    checks++;
    if ({q, r} !== {32'd100, 32'd0}) $display("[TB] FAIL b2b_qr: got %0d/%0d required 100/0", q, r);
    else passed++;
    checks++;
    if (busy_after !== 1'b0) $display("[TB] FAIL b2b_start_in_done_ignored: busy got %b required 0", busy_after);
    else passed++;
  endtask

  task automatic test_abort();
    int lat;
    int ndone = 0;
    logic bacc;
    @(negedge clk);
    a = 32'd1000; b = 32'd3; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, q, r, n, z, c, v} !== 70'd0)
      $display("[TB] FAIL abort_outputs: got %h required 0", {busy, done, q, r, n, z, c, v});
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) $display("[TB] FAIL abort_no_done: got %0d required 0", ndone);
    else passed++;
    run_op(32'd9, 32'd3, 1'b0, lat, bacc);
    checks++;
    if (lat !== 34) $display("[TB] FAIL abort_restart_latency: got %0d required 34", lat);
    else passed++;
    checks++;
    if ({q, r} !== {32'd3, 32'd0}) $display("[TB] FAIL abort_restart_qr: got %0d/%0d required 3/0", q, r);
    else passed++;
    checks++;
    if ({n, z, c, v} !== 4'b0000) $display("[TB] FAIL abort_restart_flags: got %b required 0000", {n, z, c, v});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
